// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, ALU operations, FSM states
// and the opcode decoder.
package core_pkg;

    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_SUB  = 6'b011000;
    localparam logic [5:0] OP_AND  = 6'b100000;
    localparam logic [5:0] OP_OR   = 6'b101000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ORI  = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOP, ALU_HALT
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_HALT
    } state_e;

    typedef struct packed {
        alu_op_e op;
        logic    use_imm;
        logic    we;
        logic    dst_rt;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] opcode);
        dec_t d;
        d = '{op: ALU_NOP, use_imm: 1'b0, we: 1'b0, dst_rt: 1'b0};
        case (opcode)
            OP_ADD:  d = '{op: ALU_ADD,  use_imm: 1'b0, we: 1'b1, dst_rt: 1'b0};
            OP_SUB:  d = '{op: ALU_SUB,  use_imm: 1'b0, we: 1'b1, dst_rt: 1'b0};
            OP_AND:  d = '{op: ALU_AND,  use_imm: 1'b0, we: 1'b1, dst_rt: 1'b0};
            OP_OR:   d = '{op: ALU_OR,   use_imm: 1'b0, we: 1'b1, dst_rt: 1'b0};
            OP_ADDI: d = '{op: ALU_ADD,  use_imm: 1'b1, we: 1'b1, dst_rt: 1'b1};
            OP_ORI:  d = '{op: ALU_OR,   use_imm: 1'b1, we: 1'b1, dst_rt: 1'b1};
            OP_HALT: d = '{op: ALU_HALT, use_imm: 1'b0, we: 1'b0, dst_rt: 1'b0};
            default: d = '{op: ALU_NOP,  use_imm: 1'b0, we: 1'b0, dst_rt: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Control, program-load and status signals of the multicycle core.
interface multicycle_core_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 3
);
    logic              control;
    logic              run_mode;
    logic              imem_we;
    logic [PC_W-1:0]   imem_waddr;
    logic [31:0]       imem_wdata;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              halted;

    modport master (
        output control, run_mode, imem_we, imem_waddr, imem_wdata,
        input  result, pc, busy, halted
    );

    modport slave (
        input  control, run_mode, imem_we, imem_waddr, imem_wdata,
        output result, pc, busy, halted
    );
endinterface

// File: rtl/multicycle_core_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 fixed at zero.
module core_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_REGS)-1:0] ra,
    input  logic [$clog2(NUM_REGS)-1:0] rb,
    output logic [DATA_W-1:0]           rd_a,
    output logic [DATA_W-1:0]           rd_b,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] wa,
    input  logic [DATA_W-1:0]           wd
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd_a = (ra == '0) ? '0 : regs[ra];
    assign rd_b = (rb == '0) ? '0 : regs[rb];
endmodule

// File: rtl/multicycle_core.sv
// Four-cycle-per-instruction core: FETCH/DECODE/EXECUTE/WRITEBACK FSM, ALU and
// inferred instruction memory, with single-step or free-run sequencing.
module multicycle_core
    import core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int IMEM_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_core_if.slave   bus
);
    localparam int PC_W   = $clog2(IMEM_DEPTH);
    localparam int RIDX_W = $clog2(NUM_REGS);

    logic rst_q1, rst_n;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {rst_n, rst_q1} <= '0;
        else        {rst_n, rst_q1} <= {rst_q1, 1'b1};
    end

    state_e            state, state_next;
    logic [31:0]       imem [IMEM_DEPTH];
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc_q, pc_next;
    logic [DATA_W-1:0] op_a, op_b, imm_q, alu_q, result_q;
    logic [DATA_W-1:0] rd_a, rd_b, imm_ext, opnd_b, alu_out;
    logic              ctrl_q, ctrl_rise, fetch, wb_we, imem_wr;
    logic [RIDX_W-1:0] wa;
    dec_t              dec;

    assign dec       = decode(ir[31:26]);
    assign ctrl_rise = bus.control & ~ctrl_q;
    assign imm_ext   = DATA_W'($signed(ir[15:0]));
    assign wa        = dec.dst_rt ? ir[16 +: RIDX_W] : ir[11 +: RIDX_W];

    core_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .ra   (ir[21 +: RIDX_W]),
        .rb   (ir[16 +: RIDX_W]),
        .rd_a (rd_a),
        .rd_b (rd_b),
        .we   (wb_we),
        .wa   (wa),
        .wd   (alu_q)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        fetch      = 1'b0;
        wb_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.run_mode || ctrl_rise) begin
                    state_next = ST_FETCH;
                    fetch      = 1'b1;
                end
            end
            ST_FETCH:   state_next = ST_DECODE;
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (dec.op == ALU_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    pc_next = pc_q + 1'b1;
                    wb_we   = dec.we;
                    if (bus.run_mode) begin
                        state_next = ST_FETCH;
                        fetch      = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        opnd_b  = dec.use_imm ? imm_q : op_b;
        alu_out = '0;
        case (dec.op)
            ALU_ADD: alu_out = op_a + opnd_b;
            ALU_SUB: alu_out = op_a - opnd_b;
            ALU_AND: alu_out = op_a & opnd_b;
            ALU_OR:  alu_out = op_a | opnd_b;
            default: alu_out = '0;
        endcase
    end

    // IR loads on the edge entering FETCH, so a same-edge imem write in IDLE
    // is not seen by that fetch while back-to-back run mode keeps 4 cycles/instr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc_q     <= '0;
            ctrl_q   <= 1'b0;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            result_q <= '0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            ctrl_q <= bus.control;
            if (fetch) ir <= imem[pc_next];
            if (state == ST_DECODE) begin
                op_a  <= rd_a;
                op_b  <= rd_b;
                imm_q <= imm_ext;
            end
            if (state == ST_EXECUTE) alu_q <= alu_out;
            if (wb_we) result_q <= alu_q;
        end
    end

    assign imem_wr = bus.imem_we && (state == ST_IDLE || state == ST_HALT);

    always_ff @(posedge clk) begin
        if (imem_wr) imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    assign bus.result = result_q;
    assign bus.pc     = pc_q;
    assign bus.busy   = (state == ST_FETCH) || (state == ST_DECODE) ||
                        (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign bus.halted = (state == ST_HALT);
endmodule
